// File: rtl/xoodoo_word_reader_sca.sv
// Readout sequencer for the two-share Xoodoo state: steps a word index over the
// rate, captures each share pair and streams it out, truncating the final word.
module xoodoo_word_reader_sca #(
  parameter int MAX_WORDS = 12,
  parameter int WORD_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [3:0]          num_words_i,
  input  logic [2:0]          last_bytes_i,
  output logic [3:0]          word_index_o,
  input  logic [2*WORD_W-1:0] word_i,
  output logic                busy_o,
  output logic [2*WORD_W-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic [2:0]          bytes_o,
  output logic                done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [3:0] MAX_N = 4'(MAX_WORDS);

  state_t              state;
  logic [3:0]          last_idx;
  logic [2:0]          lb;
  logic [3:0]          n_clamped;
  logic [2:0]          lb_in;
  logic                load;
  logic                is_last;
  logic [WORD_W-1:0]   mask;
  logic [2*WORD_W-1:0] masked;

  // Keeps bytes below nbytes; both shares get the same mask so no share is
  // ever combined or partially exposed.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nbytes);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int k = 0; k < WORD_W / 8; k++) begin
      if (k < int'(nbytes)) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

  always_comb begin
    n_clamped = (num_words_i > MAX_N) ? MAX_N : num_words_i;
    lb_in     = (last_bytes_i == 3'd0 || last_bytes_i > 3'd4) ? 3'd4 : last_bytes_i;
    load      = ~valid_o | ready_i;
    is_last   = (word_index_o == last_idx);
    mask      = byte_mask(lb);
    masked    = {word_i[2*WORD_W-1:WORD_W] & mask, word_i[WORD_W-1:0] & mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_index_o <= '0;
      data_o       <= '0;
      bytes_o      <= '0;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      last_idx     <= '0;
      lb           <= 3'd4;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            word_index_o <= '0;
            lb           <= lb_in;
            if (n_clamped == 4'd0) begin
              done_o <= 1'b1;
            end else begin
              last_idx <= n_clamped - 4'd1;
              busy_o   <= 1'b1;
              state    <= READ;
            end
          end
        end

        READ: begin
          if (load) begin
            data_o       <= is_last ? masked : word_i;
            valid_o      <= 1'b1;
            last_o       <= is_last;
            bytes_o      <= is_last ? lb : 3'd4;
            word_index_o <= word_index_o + 4'd1;
            if (is_last) state <= DRAIN;
          end
        end

        DRAIN: begin
          // The index rests at n here until the final word is taken.
          if (valid_o && ready_i) begin
            valid_o      <= 1'b0;
            last_o       <= 1'b0;
            done_o       <= 1'b1;
            busy_o       <= 1'b0;
            word_index_o <= '0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_word_reader_sca.sv
// Self-checking bench for xoodoo_word_reader_sca: a word-array state model and
// an expected-stream model checked with immediate assertions.
module tb_xoodoo_word_reader_sca;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [3:0]  num_words_i;
  logic [2:0]  last_bytes_i;
  logic [3:0]  word_index_o;
  logic [63:0] word_i;
  logic        busy_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic [2:0]  bytes_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [16];

  always #5 clk = ~clk;

  assign word_i = mem[word_index_o];

  xoodoo_word_reader_sca dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .num_words_i  (num_words_i),
    .last_bytes_i (last_bytes_i),
    .word_index_o (word_index_o),
    .word_i       (word_i),
    .busy_o       (busy_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .bytes_o      (bytes_o),
    .done_o       (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected word k of an n-word readout; the final word keeps only lbe bytes per share.
  function automatic logic [63:0] expect_word(input int k, input int n, input int lbe);
    logic [31:0] m;
    m = (lbe >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * lbe)) - 32'd1);
    if (k != n - 1) return mem[k];
    return {mem[k][63:32] & m, mem[k][31:0] & m};
  endfunction

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 16; i++) begin
      if (kind == 1) mem[i] = {32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)};
      else           mem[i] = {$urandom, $urandom};
    end
    if (kind == 2) mem[2] = {32'h1122_3344, 32'h5566_7788};
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic run_read(input int nw, input int lbv, input int mode, input bit inject, input int fill);
    int n, lbe, got, done_c, c;
    bit holding;
    logic [63:0] hold_data;
    logic [3:0]  hold_meta;
    n = (nw > 12) ? 12 : nw;
    lbe = (lbv == 0) ? 4 : lbv;
    fill_mem(fill);
    start_i = 1'b1;
    num_words_i = 4'(nw);
    last_bytes_i = 3'(lbv);
    @(posedge clk); #1;
    start_i = 1'b0;
    num_words_i = 4'($urandom);
    last_bytes_i = 3'($urandom);
    got = 0; done_c = 0; holding = 1'b0; hold_data = '0; hold_meta = '0;
    for (c = 1; c <= 4 * n + 20; c++) begin
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (c % 3 == 2);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      if (inject && c == 4) begin
        start_i = 1'b1; num_words_i = 4'd2; last_bytes_i = 3'd1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      if (holding) begin
        check("hold_data", data_o, hold_data);
        check("hold_meta", {valid_o, last_o, bytes_o}, {1'b1, hold_meta});
      end
      check("index_range", 64'(word_index_o <= 4'(n)), 64'd1);
      if (valid_o && ready_i) begin
        check("no_extra_word", 64'(got < n), 64'd1);
        if (got < n) begin
          check("data", data_o, expect_word(got, n, lbe));
          check("last", 64'(last_o), 64'(got == n - 1));
          check("bytes", 64'(bytes_o), (got == n - 1) ? 64'(lbe) : 64'd4);
        end
        if (mode == 0) check("word_timing", 64'(c), 64'(got + 2));
        got++;
      end
      holding = valid_o && !ready_i;
      hold_data = data_o;
      hold_meta = {last_o, bytes_o};
      if (done_o) begin
        done_c = c;
        break;
      end
      check("busy", 64'(busy_o), 64'(n > 0));
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    check("done_seen", 64'(done_c != 0), 64'd1);
    check("word_count", 64'(got), 64'(n));
    if (mode == 0) check("done_cycle", 64'(done_c), (n == 0) ? 64'd1 : 64'(n + 2));
    check("done_state", {busy_o, valid_o, word_index_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ready_i = 1'(i & 1);
      @(negedge clk);
      check("quiet_after_done", {done_o, valid_o, busy_o}, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    num_words_i = '0;
    last_bytes_i = '0;
    ready_i = 1'b0;
    fill_mem(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_index", 64'(word_index_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_bytes", 64'(bytes_o), 64'd0);
    check("rst_flags", {valid_o, last_o, busy_o, done_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_read(6, 4, 0, 1'b0, 1);
    run_read(3, 2, 0, 1'b0, 2);
    run_read(4, 3, 1, 1'b0, 0);
    run_read(0, 3, 0, 1'b0, 0);
    run_read(15, 1, 0, 1'b0, 0);

    // Abort mid-read while word 2 is on the output.
    fill_mem(0);
    ready_i = 1'b1;
    start_i = 1'b1; num_words_i = 4'd6; last_bytes_i = 3'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_abort_word2", {63'd0, valid_o}, 64'd1);
    check("pre_abort_data", data_o, mem[2]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_flags", {valid_o, busy_o, done_o, last_o}, 64'd0);
    check("abort_index", 64'(word_index_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_done", {done_o, valid_o}, 64'd0);
    end
    @(posedge clk); #1;
    run_read(6, 4, 0, 1'b0, 0);

    run_read(5, 3, 0, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      run_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 2, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xoodoo_word_reader_sca.md
Name: xoodoo_word_reader_sca

Overview:
- Readout/squeeze sequencer for the two-share Xoodoo state register.
- Once the permutation is idle, it steps a word index over the rate part of the state and captures the two-share word returned for each index.
- It presents each captured word on a valid/ready output stream toward the Xoodyak output/unmasking stage.
- Shares are never combined inside this block; the final word is truncated to the requested byte count.

Parameters:
- MAX_WORDS, 12, maximum words per readout; a larger num_words_i is clamped to this value.
- WORD_W, 32, width of one share word.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start_i  in  1  start a readout; sampled only in IDLE
- num_words_i  in  4  number of words to read, 0..12
- last_bytes_i  in  3  valid bytes in the final word; 1..4 as given, 0 treated as 4
- word_index_o  out  4  word index driven to the state register
- word_i  in  2*WORD_W  state word from the register; share0 in [63:32], share1 in [31:0]; combinational from word_index_o
- busy_o  out  1  high in READ and DRAIN
- data_o  out  2*WORD_W  captured word, same share layout as word_i
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer ready
- last_o  out  1  data_o is the final word of this readout
- bytes_o  out  3  valid bytes in data_o: 4, or the final-word count
- done_o  out  1  one-cycle pulse when the readout completes

Behaviour:
- Reset values:
  - word_index_o=0, data_o=0, bytes_o=0.
  - valid_o, last_o, busy_o and done_o are all 0.
  - State is IDLE.
- Reset mid-operation aborts immediately to these values; no partial output and no done_o pulse.
- States: IDLE, READ, DRAIN.
- IDLE:
  - On start_i=1, latch n = min(num_words_i, MAX_WORDS) and lb (0→4), and set word_index_o=0.
  - If n=0: go directly to IDLE-done, pulsing done_o the next cycle with no stream output.
  - Otherwise go to READ.
- READ:
  - load = ~valid_o | ready_i.
  - When load=1, capture word_i into data_o, set valid_o=1 and increment word_index_o.
  - bytes_o = (index == n-1) ? lb : 4.
  - last_o = (index == n-1).
  - When the word at index n-1 is loaded, go to DRAIN; word_index_o then holds at n.
  - When load=0, hold everything; word_index_o is stable.
- Final-word masking:
  - Bytes at or above lb are zeroed in both shares of the final word.
  - Byte k occupies bits [8k+7:8k] of each share.
  - Zeroing both shares yields a recombined value of 0; no unmasked data is produced.
- DRAIN: on valid_o & ready_i, clear valid_o and last_o, pulse done_o on the following cycle, then go to IDLE with word_index_o=0.
- Timing:
  - start_i at cycle t gives the first valid_o at t+2.
  - With ready_i held high, the stream is 1 word/cycle and word k is valid at t+2+k.
  - done_o fires the cycle after the final handshake.
- Backpressure:
  - data_o, last_o and bytes_o are stable while valid_o=1 and ready_i=0.
  - No word is skipped or duplicated.
- start_i while busy_o=1 is ignored, and so are num_words_i/last_bytes_i changes after the start cycle.
- The state register must not update while busy_o=1; the controller guarantees this (start_in/running_in/word_enable_in low).
- done_o and start_i in the same cycle: the new start is accepted, since the state is already IDLE.

Test Plan:
- Full read: state words i = {0xA000_000i, 0x5000_000i}, start with num_words=6 and last_bytes=4, ready held 1 → six words on consecutive cycles t+2..t+7 with index 0..5, last_o only on word 5, bytes_o=4 throughout, done_o at t+8.
- Partial final word: num_words=3, last_bytes=2, word 2 = {0x11223344, 0x55667788} → data_o={0x00003344, 0x00007788}, bytes_o=2, last_o=1.
- Backpressure: num_words=4 with ready toggling 1,0,0,1,... → each word held stable while ready=0, all 4 delivered in order, word_index_o never exceeds 4, no duplicates.
- Zero length and clamp: num_words=0 → no valid_o, done_o at t+1; num_words=15 → exactly 12 words (index 0..11).
- Reset mid-read: assert rst during word 2 of 6 → next cycle valid_o=0, busy_o=0, word_index_o=0, no done_o; a new start then runs cleanly.
- Ignored start: pulse start_i with num_words=2 during an active 5-word read → exactly 5 words and a single done_o.
